// File: rtl/frame_sync_ctrl_pkg.sv
// Shared definitions for the frame synchronisation controller.
// Holds the game state codes used by the stage logic, the vertical timing
// constants of the display raster, and the handshake FSM encoding.
package frame_sync_ctrl_pkg;

    // First vertical-blank line, and lines per frame (v_cnt runs 0..V_TOTAL-1).
    localparam int V_ACTIVE = 480;
    localparam int V_TOTAL  = 525;

    typedef enum logic [3:0] {
        TITLE    = 4'd0,
        STAFF    = 4'd1,
        STAGE1   = 4'd2,
        SUCCESS1 = 4'd3,
        STAGE2   = 4'd4,
        SUCCESS2 = 4'd5,
        STAGE3   = 4'd6,
        SUCCESS3 = 4'd7,
        FAIL     = 4'd8,
        HELP     = 4'd9
    } game_state_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_COMMIT = 3'd2,
        S_ACK    = 3'd3,
        S_HOLD   = 3'd4
    } sync_state_t;

endpackage

// File: rtl/frame_sync_ctrl_anim_divider.sv
// Sprite animation divider.
// Counts frame ticks 0..ANIM_DIV-1; each wrap advances the 2-bit animation
// phase (wrapping 3->0). A synchronous clear restarts both the count and the
// phase and takes priority over a tick arriving on the same edge.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   tick        one-cycle frame tick
//   clear       synchronous restart of divider and phase
//   anim_phase  current sprite animation phase
module anim_divider #(
    parameter int ANIM_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       clear,
    output logic [1:0] anim_phase
);

    localparam int DW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(ANIM_DIV - 1);

    logic [DW-1:0] div;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div        <= '0;
            anim_phase <= 2'd0;
        end else if (clear) begin
            div        <= '0;
            anim_phase <= 2'd0;
        end else if (tick) begin
            if (div == DIV_LAST) begin
                div        <= '0;
                anim_phase <= anim_phase + 2'd1;
            end else begin
                div <= div + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_sync_ctrl.sv
// Frame synchronisation controller between game logic and the compositor.
// Keeps shadow copies of every game variable the compositor reads and only
// refreshes them during vertical blank, so a frame never mixes old and new
// positions. Also produces the frame tick, a free-running frame counter and
// the sprite animation phase.
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   h_cnt, v_cnt       raster position from the sync generator
//   upd_req            level request from game logic (in_* held while high)
//   in_*               new game variable values
//   upd_ack            one-cycle pulse once the commit has completed
//   state..life        shadow registers read by the compositor
//   frame_tick         one-cycle pulse at the start of each vblank
//   anim_phase         sprite animation phase
//   frame_cnt          free-running frame counter
module frame_sync_ctrl
    import frame_sync_ctrl_pkg::*;
#(
    parameter int ANIM_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h_cnt,
    input  logic [9:0] v_cnt,
    input  logic       upd_req,
    input  logic [3:0] in_state,
    input  logic [3:0] in_player_state,
    input  logic [3:0] in_boss_state,
    input  logic [8:0] in_player_x,
    input  logic [8:0] in_player_y,
    input  logic [8:0] in_boss_x,
    input  logic [8:0] in_boss_y,
    input  logic [8:0] in_obj_x,
    input  logic [8:0] in_obj_y,
    input  logic [1:0] in_key_find,
    input  logic [1:0] in_life,
    output logic       upd_ack,
    output logic [3:0] state,
    output logic [3:0] player_state,
    output logic [3:0] boss_state,
    output logic [8:0] player_x,
    output logic [8:0] player_y,
    output logic [8:0] boss_x,
    output logic [8:0] boss_y,
    output logic [8:0] obj_x,
    output logic [8:0] obj_y,
    output logic [1:0] key_find,
    output logic [1:0] life,
    output logic       frame_tick,
    output logic [1:0] anim_phase,
    output logic [7:0] frame_cnt
);

    localparam logic [9:0] V_ACTIVE_L = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST_L   = 10'(V_TOTAL - 1);

    sync_state_t sync_st, sync_nx;
    logic        window;
    logic        commit;
    logic        state_change;
    logic        tick_cond;

    // The last blank line is kept out of the window so shadows settle a full
    // line before active video resumes.
    assign window       = (v_cnt >= V_ACTIVE_L) && (v_cnt != V_LAST_L);
    assign commit       = (sync_st == S_COMMIT);
    assign state_change = commit && (in_state != state);
    assign tick_cond    = (v_cnt == V_ACTIVE_L) && (h_cnt == 10'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_st <= S_IDLE;
        end else begin
            sync_st <= sync_nx;
        end
    end

    // A dropped request while waiting is a protocol violation and is simply
    // abandoned; a request held high past ACK parks in HOLD so it can never
    // trigger a second commit.
    always_comb begin
        sync_nx = sync_st;
        case (sync_st)
            S_IDLE: begin
                if (upd_req) begin
                    sync_nx = window ? S_COMMIT : S_WAIT;
                end
            end
            S_WAIT: begin
                if (!upd_req) begin
                    sync_nx = S_IDLE;
                end else if (window) begin
                    sync_nx = S_COMMIT;
                end
            end
            S_COMMIT: sync_nx = S_ACK;
            S_ACK:    sync_nx = upd_req ? S_HOLD : S_IDLE;
            S_HOLD: begin
                if (!upd_req) begin
                    sync_nx = S_IDLE;
                end
            end
            default:  sync_nx = S_IDLE;
        endcase
    end

    // The ack is registered from the ACK state so it leaves no combinational
    // path; it becomes visible the cycle after the shadows were written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_ack <= 1'b0;
        end else begin
            upd_ack <= (sync_st == S_ACK);
        end
    end

    // All shadows are loaded on the same edge so the compositor sees one
    // consistent snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= TITLE;
            player_state <= 4'd0;
            boss_state   <= 4'd0;
            player_x     <= 9'd0;
            player_y     <= 9'd0;
            boss_x       <= 9'd0;
            boss_y       <= 9'd0;
            obj_x        <= 9'd0;
            obj_y        <= 9'd0;
            key_find     <= 2'd0;
            life         <= 2'd0;
        end else if (commit) begin
            state        <= in_state;
            player_state <= in_player_state;
            boss_state   <= in_boss_state;
            player_x     <= in_player_x;
            player_y     <= in_player_y;
            boss_x       <= in_boss_x;
            boss_y       <= in_boss_y;
            obj_x        <= in_obj_x;
            obj_y        <= in_obj_y;
            key_find     <= in_key_find;
            life         <= in_life;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_tick <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            frame_tick <= tick_cond;
            if (tick_cond) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // A change of game state restarts the animation so each new screen
    // begins on phase 0.
    anim_divider #(
        .ANIM_DIV (ANIM_DIV)
    ) u_anim_divider (
        .clk        (clk),
        .rst        (rst),
        .tick       (frame_tick),
        .clear      (state_change),
        .anim_phase (anim_phase)
    );

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Self-checking bench for frame_sync_ctrl.
// The bench drives a compact raster (4 columns per line, optional skip of
// most active lines), issues randomized update requests, and predicts commit
// timing, shadow contents, frame ticks, frame count and animation phase from
// the behavioural rules; a separate monitor compares against the DUT.
module tb_frame_sync_ctrl;
    import frame_sync_ctrl_pkg::*;

    localparam int ANIM_DIV = 8;
    localparam int H_TOTAL  = 4;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] ps;
        logic [3:0] bs;
        logic [8:0] px;
        logic [8:0] py;
        logic [8:0] bx;
        logic [8:0] by;
        logic [8:0] ox;
        logic [8:0] oy;
        logic [1:0] kf;
        logic [1:0] lf;
    } shadow_t;

    typedef struct {
        shadow_t v;
        int      ack_cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       upd_req;
    logic [3:0] in_state, in_player_state, in_boss_state;
    logic [8:0] in_player_x, in_player_y, in_boss_x, in_boss_y, in_obj_x, in_obj_y;
    logic [1:0] in_key_find, in_life;
    logic       upd_ack;
    logic [3:0] state, player_state, boss_state;
    logic [8:0] player_x, player_y, boss_x, boss_y, obj_x, obj_y;
    logic [1:0] key_find, life;
    logic       frame_tick;
    logic [1:0] anim_phase;
    logic [7:0] frame_cnt;

    frame_sync_ctrl #(
        .ANIM_DIV (ANIM_DIV)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .h_cnt           (h_cnt),
        .v_cnt           (v_cnt),
        .upd_req         (upd_req),
        .in_state        (in_state),
        .in_player_state (in_player_state),
        .in_boss_state   (in_boss_state),
        .in_player_x     (in_player_x),
        .in_player_y     (in_player_y),
        .in_boss_x       (in_boss_x),
        .in_boss_y       (in_boss_y),
        .in_obj_x        (in_obj_x),
        .in_obj_y        (in_obj_y),
        .in_key_find     (in_key_find),
        .in_life         (in_life),
        .upd_ack         (upd_ack),
        .state           (state),
        .player_state    (player_state),
        .boss_state      (boss_state),
        .player_x        (player_x),
        .player_y        (player_y),
        .boss_x          (boss_x),
        .boss_y          (boss_y),
        .obj_x           (obj_x),
        .obj_y           (obj_y),
        .key_find        (key_find),
        .life            (life),
        .frame_tick      (frame_tick),
        .anim_phase      (anim_phase),
        .frame_cnt       (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    int   acks_seen  = 0;
    int   ticks_seen = 0;
    bit   fast       = 1'b0;
    bit   tick_edge  = 1'b0;
    bit   rst_edge   = 1'b1;
    exp_t expq[$];

    // Reference model state, owned by the monitor.
    shadow_t m_shadow   = '0;
    int      m_frames   = 0;
    int      m_fcnt     = 0;
    bit      tick_prev  = 1'b0;

    task automatic cmp(input string name, input logic [95:0] got, input logic [95:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic checkOutput(input string name, input int got, input int exp);
        cmp(name, 96'(got), 96'(exp));
    endtask

    function automatic shadow_t read_dut();
        return {state, player_state, boss_state, player_x, player_y, boss_x,
                boss_y, obj_x, obj_y, key_find, life};
    endfunction

    function automatic shadow_t rand_shadow();
        shadow_t s;
        s.st = 4'($urandom_range(0, 9));
        s.ps = 4'($urandom);
        s.bs = 4'($urandom);
        s.px = 9'($urandom);
        s.py = 9'($urandom);
        s.bx = 9'($urandom);
        s.by = 9'($urandom);
        s.ox = 9'($urandom);
        s.oy = 9'($urandom);
        s.kf = 2'($urandom);
        s.lf = 2'($urandom);
        return s;
    endfunction

    task automatic drive(input shadow_t s);
        in_state        = s.st;
        in_player_state = s.ps;
        in_boss_state   = s.bs;
        in_player_x     = s.px;
        in_player_y     = s.py;
        in_boss_x       = s.bx;
        in_boss_y       = s.by;
        in_obj_x        = s.ox;
        in_obj_y        = s.oy;
        in_key_find     = s.kf;
        in_life         = s.lf;
    endtask

    // Raster walk; in fast mode lines 6..469 are skipped to shorten frames.
    function automatic void next_pos(input int h, input int v, input bit f,
                                     output int nh, output int nv);
        nh = h;
        nv = v;
        if (h == H_TOTAL - 1) begin
            nh = 0;
            nv = (v == V_TOTAL - 1) ? 0 : v + 1;
            if (f && nv == 6) nv = 470;
        end else begin
            nh = h + 1;
        end
    endfunction

    function automatic bit in_window(input int v);
        return (v >= V_ACTIVE) && (v != V_TOTAL - 1);
    endfunction

    function automatic int cycles_to_window(input int h, input int v, input bit f);
        int k = 0;
        int nh, nv;
        while (!in_window(v) && k < 5000) begin
            next_pos(h, v, f, nh, nv);
            h = nh;
            v = nv;
            k++;
        end
        return k;
    endfunction

    task automatic step();
        int nh, nv;
        @(posedge clk);
        cyc++;
        rst_edge  = rst;
        tick_edge = !rst && (v_cnt == 10'(V_ACTIVE)) && (h_cnt == 10'd0);
        if (tick_edge) ticks_seen++;
        #1;
        next_pos(int'(h_cnt), int'(v_cnt), fast, nh, nv);
        h_cnt = 10'(nh);
        v_cnt = 10'(nv);
    endtask

    task automatic run_to(input int v, input int h);
        int budget = 3000;
        while (!(v_cnt == 10'(v) && h_cnt == 10'(h)) && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL run_to: got v=%0d h=%0d, expected v=%0d h=%0d", v_cnt, h_cnt, v, h);
        end
    endtask

    task automatic run_ticks(input int n);
        int target = ticks_seen + n;
        int budget = n * 2200 + 10;
        while (ticks_seen < target && budget > 0) begin
            step();
            budget--;
        end
        if (ticks_seen < target) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL tick_timeout: got %0d ticks, expected %0d", ticks_seen, target);
        end
    endtask

    // Raise a request at the current raster position; the ack is expected
    // two cycles after the first window cycle seen by the request.
    task automatic applyStimulus(input shadow_t s, input int hold);
        exp_t e;
        int   k, seen, budget;
        drive(s);
        upd_req   = 1'b1;
        k         = cycles_to_window(int'(h_cnt), int'(v_cnt), fast);
        e.v       = s;
        e.ack_cyc = cyc + 1 + k + 2;
        expq.push_back(e);
        seen   = acks_seen;
        budget = k + 20;
        while (acks_seen == seen && budget > 0) begin
            step();
            budget--;
        end
        if (acks_seen == seen) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL ack_timeout: got no upd_ack, expected one at cycle %0d", e.ack_cyc);
            expq.delete();
        end
        repeat (hold) step();
        upd_req = 1'b0;
        repeat (3) step();
    endtask

    always @(negedge clk) begin : monitor
        shadow_t got;
        exp_t    e;
        bit      commit_now, chg;
        got = read_dut();
        if (rst || rst_edge) begin
            m_shadow  = '0;
            m_frames  = 0;
            m_fcnt    = 0;
            tick_prev = 1'b0;
            cmp("reset_outputs", 96'({got, upd_ack, frame_tick, anim_phase, frame_cnt}), 96'd0);
        end else begin
            commit_now = (expq.size() > 0) && (expq[0].ack_cyc - 1 == cyc);
            chg = 1'b0;
            if (commit_now) begin
                chg      = (expq[0].v.st != m_shadow.st);
                m_shadow = expq[0].v;
                if (chg) m_frames = 0;
            end
            if (tick_prev && !chg) m_frames++;
            if (tick_edge) m_fcnt = (m_fcnt + 1) % 256;

            if (upd_ack) begin
                if (expq.size() == 0) begin
                    cmp("unexpected_ack", 96'(upd_ack), 96'd0);
                end else begin
                    e = expq.pop_front();
                    checkOutput("ack_cycle", cyc, e.ack_cyc);
                    cmp("ack_shadows", 96'(got), 96'(e.v));
                    acks_seen++;
                end
            end
            if (frame_tick || tick_edge) cmp("frame_tick", 96'(frame_tick), 96'(tick_edge));
            if (tick_edge) begin
                checkOutput("frame_cnt", int'(frame_cnt), m_fcnt);
                cmp("tick_shadows", 96'(got), 96'(m_shadow));
            end
            if (tick_prev || upd_ack)
                checkOutput("anim_phase", int'(anim_phase), (m_frames / ANIM_DIV) % 4);
            tick_prev = tick_edge;
        end
    end

    initial begin
        shadow_t s;
        rst     = 1'b1;
        h_cnt   = 10'd0;
        v_cnt   = 10'd0;
        upd_req = 1'b1;
        drive(rand_shadow());
        $display("[TB] reset with random inputs and a live request");
        repeat (5) step();
        upd_req = 1'b0;
        rst     = 1'b0;
        step();

        $display("[TB] request during active video at line 100");
        run_to(100, 0);
        s    = rand_shadow();
        s.px = 9'd200;
        applyStimulus(s, 0);

        $display("[TB] request inside blank, held high, then re-raised");
        run_to(490, 0);
        applyStimulus(rand_shadow(), 20);
        applyStimulus(rand_shadow(), 0);

        $display("[TB] request on the last blank line");
        run_to(524, 2);
        applyStimulus(rand_shadow(), 0);

        $display("[TB] request dropped while waiting");
        run_to(100, 0);
        drive(rand_shadow());
        upd_req = 1'b1;
        repeat (10) step();
        upd_req = 1'b0;
        repeat (3) step();

        $display("[TB] randomized requests");
        for (int i = 0; i < 6; i++) begin
            run_to($urandom_range(0, V_TOTAL - 1), $urandom_range(0, H_TOTAL - 1));
            applyStimulus(rand_shadow(), $urandom_range(0, 5));
        end

        $display("[TB] reset while waiting");
        run_to(100, 0);
        drive(rand_shadow());
        upd_req = 1'b1;
        repeat (5) step();
        rst = 1'b1;
        expq.delete();
        repeat (3) step();
        upd_req = 1'b0;
        rst     = 1'b0;
        step();
        cmp("after_reset_shadows", 96'(read_dut()), 96'd0);

        $display("[TB] 32 frames of animation");
        fast = 1'b1;
        run_ticks(32);
        checkOutput("frame_cnt_32", int'(frame_cnt), 32);
        step();
        checkOutput("anim_phase_32", int'(anim_phase), 0);

        $display("[TB] state change colliding with a frame tick");
        run_to(3, 0);
        s    = rand_shadow();
        s.st = 4'(STAGE1);
        applyStimulus(s, 0);
        run_ticks(23);
        step();
        checkOutput("anim_phase_23", int'(anim_phase), 2);
        run_to(V_ACTIVE, 0);
        s    = rand_shadow();
        s.st = 4'(STAGE2);
        applyStimulus(s, 0);
        checkOutput("anim_after_change", int'(anim_phase), 0);
        checkOutput("state_after_change", int'(state), 4);

        repeat (5) step();
        checkOutput("pending_acks", expq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
